ps2_kbd_fifo: RTL and testbench

//   Keyboard-side responder for the MIO bus keyboard port (address 0xF...8).
//   - Receives PS/2 device-to-host frames and buffers scancodes in a FIFO.
//   - Presents the FIFO head on keyboard_data.
//   - Pops one entry per CPU read strobe (keyboard_rdn low).
//   - Sits between the PS/2 pins and the bus decoder's keyboard_data/keyboard_rdn.

---
 rtl/ps2_kbd_fifo.sv | 191 +++++++++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo
//   Keyboard-side responder for the MIO bus keyboard port. It receives PS/2
//   device-to-host frames, buffers the scancodes in a FIFO and presents the
//   FIFO head to the bus decoder. Each CPU read strobe pops one entry.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous reset, active-high
//   ps2_clk       in   PS/2 clock pin (asynchronous)
//   ps2_data      in   PS/2 data pin (asynchronous)
//   keyboard_rdn  in   read strobe from bus decoder, active-low
//   keyboard_data out  FIFO head scancode, 8'h00 when empty
//   kbd_ready     out  FIFO not empty
//   kbd_overflow  out  sticky: a byte was dropped because the FIFO was full
//   frame_err     out  one-cycle pulse per rejected frame
//
// Configuration
//   PS2_PARITY_CHECK_EN  when defined, frames whose data+parity bits are not
//                        odd are rejected at the stop bit.

module ps2_kbd_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       keyboard_rdn,
    output logic [7:0] keyboard_data,
    output logic       kbd_ready,
    output logic       kbd_overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Input synchronisers; the chain idles high like the PS/2 bus.
    logic ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
    logic ps2d_meta_q, ps2d_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= ps2_clk;
            ps2c_sync_q <= ps2c_meta_q;
            ps2c_prev_q <= ps2c_sync_q;
            ps2d_meta_q <= ps2_data;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    logic fall, sample;
    assign fall   = ps2c_prev_q & ~ps2c_sync_q;
    assign sample = ps2d_sync_q;

    // RX FSM
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_pend_q, push_pend_d;
    logic          ferr_q, ferr_d;
    logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              par_q <= 1'b0;
        else if (fall && state_q == S_PARITY) par_q <= sample;
    end
    // Odd parity across data and parity bit.
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        push_pend_d = 1'b0;
        ferr_d      = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    // A high sample here is a glitch, not a start bit.
                    if (!sample) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {sample, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: state_d = S_STOP;
                default: begin
                    if (sample && par_ok) push_pend_d = 1'b1;
                    else                  ferr_d      = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                ferr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            tmo_q       <= '0;
            push_pend_q <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            push_pend_q <= push_pend_d;
            ferr_q      <= ferr_d;
        end
    end

    assign frame_err = ferr_q;

    // FIFO. shift_q stays stable after STOP until the next frame's data bits,
    // so the delayed push still sees the completed byte.
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          rdn_prev_q;
    logic          empty, full, pop_req, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop_req = rdn_prev_q & ~keyboard_rdn;
    assign do_push = push_pend_q & ~full;
    assign do_pop  = pop_req & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset low so a strobe already low when reset releases does not pop.
            rdn_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rdn_prev_q <= keyboard_rdn;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            // A drop in the same cycle as a pop still leaves the flag set.
            if (push_pend_q && full) ovf_q <= 1'b1;
            else if (do_pop)         ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign keyboard_data = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign kbd_ready     = ~empty;
    assign kbd_overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
module tb_ps2_kbd_fifo;
    localparam int DEPTH = 16;
    localparam int TMO   = 200;
    localparam int HB    = 8;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, keyboard_rdn;
    logic [7:0] keyboard_data;
    logic       kbd_ready, kbd_overflow, frame_err;

    ps2_kbd_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_rdn(keyboard_rdn), .keyboard_data(keyboard_data),
        .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ferr_n = 0, exp_ferr = 0;
    logic exp_ovf = 1'b0;
    logic [7:0] sb[$];

    always @(negedge clk) if (frame_err) ferr_n++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HB);
        ps2_clk = 1'b0;
        tick(HB);
        ps2_clk = 1'b1;
    endtask

    // Scoreboard side of a good frame.
    task automatic exp_push(input logic [7:0] d);
        if (sb.size() < DEPTH) sb.push_back(d);
        else                   exp_ovf = 1'b1;
    endtask

    // pop_at_stop drops keyboard_rdn in the cycle the frame's push is pending
    // and holds it low for 10 cycles.
    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic stop, input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ bad_par);
        ps2_data = stop;
        tick(HB);
        ps2_clk = 1'b0;
        if (pop_at_stop) begin
            tick(3);
            keyboard_rdn = 1'b0;
            tick(HB - 3);
            ps2_clk = 1'b1;
            tick(5);
            keyboard_rdn = 1'b1;
        end else begin
            tick(HB);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(6);
    endtask

    task automatic rd();
        chk("ready_before_rd", kbd_ready, 1);
        if (sb.size() > 0) chk("head", keyboard_data, sb.pop_front());
        keyboard_rdn = 1'b0;
        tick(2);
        keyboard_rdn = 1'b1;
        tick(2);
        exp_ovf = 1'b0;
        chk("ovf_after_rd", kbd_overflow, exp_ovf);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_ready"}, kbd_ready, 0);
        chk({tag, "_data"}, keyboard_data, 8'h00);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; keyboard_rdn = 1'b1;
        tick(3);
        chk_empty("reset");
        chk("reset_ovf", kbd_overflow, 0);
        chk("reset_ferr", frame_err, 0);
        rst = 1'b0;
        tick(3);

        // single frame
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0); exp_push(8'h1C);
        chk("t1_ready", kbd_ready, 1);
        chk("t1_data", keyboard_data, 8'h1C);
        chk("t1_ferr", ferr_n, exp_ferr);
        rd();
        chk_empty("t1_empty");

        // idle glitch: a falling edge with data high is not a start bit
        ps2_bit(1'b1);
        tick(4);
        chk("glitch_ferr", ferr_n, exp_ferr);
        chk_empty("glitch");

        // make/break sequence
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0); exp_push(8'h1C);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0); exp_push(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0); exp_push(8'h1C);
        rd(); rd(); rd();
        chk_empty("t2_empty");

        // wrong parity
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        exp_ferr++;
`else
        exp_push(8'h1C);
`endif
        chk("par_ferr", ferr_n, exp_ferr);
        chk("par_ready", kbd_ready, sb.size() != 0);
        while (sb.size() > 0) rd();

        // bad stop bit
        send_frame(8'h42, 1'b0, 1'b0, 1'b0); exp_ferr++;
        chk("stop_ferr", ferr_n, exp_ferr);
        chk_empty("stop");

        // timeout after 4 data bits, then a clean frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TMO + 20); exp_ferr++;
        chk("tmo_ferr", ferr_n, exp_ferr);
        chk_empty("tmo");
        send_frame(8'h23, 1'b0, 1'b1, 1'b0); exp_push(8'h23);
        chk("tmo_next_ferr", ferr_n, exp_ferr);
        rd();
        chk_empty("tmo_next");

        // overflow
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(i * 7 + 3), 1'b0, 1'b1, 1'b0);
            exp_push(8'(i * 7 + 3));
        end
        chk("full_ovf", kbd_overflow, 0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0); exp_push(8'h55);
        chk("ovf_set", kbd_overflow, exp_ovf);
        chk("ovf_head", keyboard_data, 8'h03);
        chk("ovf_sb", sb.size(), DEPTH);
        rd();
        chk("ovf_sb_after", sb.size(), DEPTH - 1);
        while (sb.size() > 0) rd();
        chk_empty("ovf_drain");

        // simultaneous push and pop at count 3; long strobe pops once
        send_frame(8'hA1, 1'b0, 1'b1, 1'b0); exp_push(8'hA1);
        send_frame(8'hB2, 1'b0, 1'b1, 1'b0); exp_push(8'hB2);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0); exp_push(8'hC3);
        chk("sim_head", keyboard_data, sb[0]);
        send_frame(8'hD4, 1'b0, 1'b1, 1'b1);
        void'(sb.pop_front());
        exp_push(8'hD4);
        chk("sim_head_adv", keyboard_data, 8'hB2);
        rd(); rd(); rd();
        chk_empty("sim_empty");
        chk("ferr_total", ferr_n, exp_ferr);

        // reset mid-frame discards the partial frame
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk_empty("rst_mid");
        send_frame(8'h11, 1'b0, 1'b1, 1'b0); exp_push(8'h11);
        rd();
        chk_empty("rst_after");
        chk("ferr_final", ferr_n, exp_ferr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
